// File: rtl/cache_monitor.sv
// Exclusive monitor and word/line adapter between the core port and cache_control.
// Holds one load-exclusive reservation; merges byte-enabled store data into the cached line.
module cache_monitor #(
  parameter int TIMEOUT = 1023,
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 28 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [29:0]        core_address,
  input  logic               core_read,
  input  logic               core_write,
  input  logic               core_lock,
  input  logic               core_clrex,
  input  logic [3:0]         core_byteenable,
  input  logic [31:0]        core_writedata,
  output logic [31:0]        core_readdata,
  output logic               core_waitrequest,
  output logic [TAG_W-1:0]   cache_tag,
  output logic [INDEX_W-1:0] cache_index,
  output logic               cache_read,
  output logic               cache_write,
  output logic               cache_lock,
  output logic [127:0]       cache_data_wr,
  input  logic               cache_waitrequest,
  input  logic [127:0]       data_rd,
  input  logic               monitor_acquire,
  input  logic               monitor_fail,
  input  logic               monitor_release,
  output logic [127:0]       monitor_update,
  output logic               monitor_commit,
  input  logic               inval_valid,
  input  logic [TAG_W-1:0]   inval_tag,
  input  logic [INDEX_W-1:0] inval_index
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]         word;
  logic [127:0]       merged;
  logic               res_valid;
  logic [TAG_W-1:0]   res_tag;
  logic [INDEX_W-1:0] res_index;
  logic [1:0]         res_word;
  logic [CNT_W-1:0]   res_count;
  logic               line_hit, clr_plain_wr, clr_inval, expire, clr;

  assign word        = core_address[1:0];
  assign cache_index = core_address[INDEX_W+1:2];
  assign cache_tag   = core_address[29:INDEX_W+2];

  assign cache_read       = core_read;
  assign cache_write      = core_write;
  assign cache_lock       = core_lock;
  assign core_waitrequest = cache_waitrequest;

  // Byte-lane merge of the store word into the line read from SRAM.
  for (genvar gw = 0; gw < 4; gw++) begin : g_word
    localparam logic [1:0] WSEL = gw;
    for (genvar gb = 0; gb < 4; gb++) begin : g_byte
      assign merged[32*gw+8*gb +: 8] = (word == WSEL && core_byteenable[gb]) ?
                                       core_writedata[8*gb +: 8] : data_rd[32*gw+8*gb +: 8];
    end
  end

  assign cache_data_wr  = merged;
  assign monitor_update = merged;

  always_comb begin
    core_readdata = data_rd[32*word +: 32];
    if (core_write && core_lock) core_readdata = {31'b0, monitor_fail};
  end

  assign line_hit       = (cache_tag == res_tag) && (cache_index == res_index);
  assign monitor_commit = res_valid && core_lock && core_write && line_hit && (word == res_word);

  assign clr_plain_wr = core_write && !core_lock && !cache_waitrequest && line_hit;
  assign clr_inval    = inval_valid && (inval_tag == res_tag) && (inval_index == res_index);
  assign expire       = (TIMEOUT != 0) && res_valid && (res_count == '0);
  assign clr          = monitor_release || clr_plain_wr || clr_inval || core_clrex || expire;

  // Any clear wins over a simultaneous acquire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_index <= '0;
      res_word  <= '0;
      res_count <= '0;
    end else if (clr) begin
      res_valid <= 1'b0;
      res_count <= '0;
    end else if (monitor_acquire) begin
      res_valid <= 1'b1;
      res_tag   <= cache_tag;
      res_index <= cache_index;
      res_word  <= word;
      res_count <= CNT_W'(TIMEOUT);
    end else if (res_valid && res_count != '0) begin
      res_count <= res_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_cache_monitor.sv
// Directed bench for cache_monitor: reservation lifecycle, merge, timeout and reset.
module tb_cache_monitor;
  localparam int INDEX_W = 8;
  localparam int TAG_W   = 20;
  localparam logic [127:0] LINE = 128'h44444444_33333333_22222222_11111111;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [29:0]        core_address;
  logic               core_read, core_write, core_lock, core_clrex;
  logic [3:0]         core_byteenable;
  logic [31:0]        core_writedata, core_readdata;
  logic               core_waitrequest;
  logic [TAG_W-1:0]   cache_tag;
  logic [INDEX_W-1:0] cache_index;
  logic               cache_read, cache_write, cache_lock;
  logic [127:0]       cache_data_wr, data_rd, monitor_update;
  logic               cache_waitrequest;
  logic               monitor_acquire, monitor_fail, monitor_release, monitor_commit;
  logic               inval_valid;
  logic [TAG_W-1:0]   inval_tag;
  logic [INDEX_W-1:0] inval_index;

  int checks = 0;
  int errors = 0;

  cache_monitor #(.TIMEOUT(4), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .core_address(core_address),
    .core_read(core_read), .core_write(core_write), .core_lock(core_lock),
    .core_clrex(core_clrex), .core_byteenable(core_byteenable),
    .core_writedata(core_writedata), .core_readdata(core_readdata),
    .core_waitrequest(core_waitrequest), .cache_tag(cache_tag),
    .cache_index(cache_index), .cache_read(cache_read), .cache_write(cache_write),
    .cache_lock(cache_lock), .cache_data_wr(cache_data_wr),
    .cache_waitrequest(cache_waitrequest), .data_rd(data_rd),
    .monitor_acquire(monitor_acquire), .monitor_fail(monitor_fail),
    .monitor_release(monitor_release), .monitor_update(monitor_update),
    .monitor_commit(monitor_commit), .inval_valid(inval_valid),
    .inval_tag(inval_tag), .inval_index(inval_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    core_read = 0; core_write = 0; core_lock = 0; core_clrex = 0;
    core_byteenable = 4'h0; core_writedata = '0;
    monitor_acquire = 0; monitor_fail = 0; monitor_release = 0;
    inval_valid = 0; inval_tag = '0; inval_index = '0;
    cache_waitrequest = 0;
  endtask

  task automatic ldrex(input logic [29:0] a);
    idle(); core_address = a; core_read = 1; core_lock = 1; monitor_acquire = 1;
  endtask

  task automatic strex(input logic [29:0] a, input logic [31:0] d, input logic fail);
    idle(); core_address = a; core_write = 1; core_lock = 1;
    core_writedata = d; core_byteenable = 4'hF; monitor_fail = fail;
  endtask

  initial begin
    idle();
    core_address = 30'h100; data_rd = LINE;
    rst_n = 0;
    core_write = 1; core_lock = 1;
    #1;
    chk("rst_commit", 128'(monitor_commit), 128'd0);
    chk("tag_pass", 128'(cache_tag), 128'h0);
    chk("idx_pass", 128'(cache_index), 128'h40);
    #12; rst_n = 1;
    tick();

    // Pass-through and plain load data
    idle(); core_address = 30'h3FFF_F102; core_read = 1; cache_waitrequest = 1; #1;
    chk("wait_hi", 128'(core_waitrequest), 128'd1);
    chk("rd_pass", 128'(cache_read), 128'd1);
    chk("tag_hi", 128'(cache_tag), 128'hFFFFC);
    chk("idx_hi", 128'(cache_index), 128'h40);
    cache_waitrequest = 0; #1;
    chk("wait_lo", 128'(core_waitrequest), 128'd0);
    chk("load_w2", 128'(core_readdata), 128'h33333333);

    // LDREX/STREX success
    ldrex(30'h100); tick();
    strex(30'h100, 32'hDEADBEEF, 1'b0); #1;
    chk("ex_commit", 128'(monitor_commit), 128'd1);
    chk("ex_update", monitor_update, 128'h44444444_33333333_22222222_DEADBEEF);
    chk("ex_status", 128'(core_readdata), 128'd0);
    chk("wr_lock", 128'({cache_write, cache_lock}), 128'h3);
    monitor_release = 1; tick(); monitor_release = 0; #1;
    chk("ex_released", 128'(monitor_commit), 128'd0);

    // Invalidation kills the reservation
    ldrex(30'h100); tick();
    idle(); inval_valid = 1; inval_tag = '0; inval_index = 8'h40; tick();
    strex(30'h100, 32'h1, 1'b1); #1;
    chk("inval_commit", 128'(monitor_commit), 128'd0);
    chk("inval_status", 128'(core_readdata), 128'd1);

    // Invalidation of another line leaves it intact
    ldrex(30'h100); tick();
    idle(); inval_valid = 1; inval_index = 8'h41; tick();
    strex(30'h100, 32'h1, 1'b0); #1;
    chk("inval_other", 128'(monitor_commit), 128'd1);

    // Word mismatch
    ldrex(30'h101); tick();
    strex(30'h102, 32'h2, 1'b1); #1;
    chk("word_miss", 128'(monitor_commit), 128'd0);
    chk("word_status", 128'(core_readdata), 128'd1);
    strex(30'h101, 32'h2, 1'b0); #1;
    chk("word_hit", 128'(monitor_commit), 128'd1);
    chk("upd_w1", monitor_update, 128'h44444444_33333333_00000002_11111111);

    // Plain write: stalled one does not clear, completed one does
    ldrex(30'h100); tick();
    idle(); core_address = 30'h103; core_write = 1; core_byteenable = 4'hF;
    cache_waitrequest = 1; tick();
    strex(30'h100, 32'h0, 1'b0); #1;
    chk("stall_keep", 128'(monitor_commit), 128'd1);
    idle(); core_address = 30'h103; core_write = 1; core_byteenable = 4'hF; tick();
    strex(30'h100, 32'h0, 1'b1); #1;
    chk("plainwr_clr", 128'(monitor_commit), 128'd0);

    // Second acquire overwrites
    ldrex(30'h100); tick();
    ldrex(30'h201); tick();
    strex(30'h100, 32'h0, 1'b1); #1;
    chk("ovr_old", 128'(monitor_commit), 128'd0);
    strex(30'h201, 32'h0, 1'b0); #1;
    chk("ovr_new", 128'(monitor_commit), 128'd1);

    // Timeout = 4
    ldrex(30'h100); tick();
    idle(); tick(2);
    strex(30'h100, 32'h0, 1'b0); #1;
    chk("to_wait2", 128'(monitor_commit), 128'd1);
    ldrex(30'h100); tick();
    idle(); tick(4);
    strex(30'h100, 32'h0, 1'b0); #1;
    chk("to_edge", 128'(monitor_commit), 128'd1);
    tick();
    chk("to_expired", 128'(monitor_commit), 128'd0);
    ldrex(30'h100); tick();
    idle(); tick(6);
    strex(30'h100, 32'h0, 1'b1); #1;
    chk("to_wait6", 128'(monitor_commit), 128'd0);

    // Byte merge on a plain write
    idle(); data_rd = 128'h11223344_33333333_22222222_11111111;
    core_address = 30'h103; core_write = 1; core_byteenable = 4'b0101;
    core_writedata = 32'hAABBCCDD; cache_waitrequest = 1; #1;
    chk("merge_wr", cache_data_wr, 128'h11BB33DD_33333333_22222222_11111111);
    chk("merge_upd", monitor_update, 128'h11BB33DD_33333333_22222222_11111111);
    chk("merge_rd", 128'(core_readdata), 128'h11223344);
    data_rd = LINE;

    // Acquire and clrex together
    ldrex(30'h100); core_clrex = 1; tick();
    strex(30'h100, 32'h0, 1'b1); #1;
    chk("acq_clrex", 128'(monitor_commit), 128'd0);

    // Reset mid-reservation
    ldrex(30'h100); tick();
    strex(30'h100, 32'h0, 1'b0); #1;
    chk("pre_rst", 128'(monitor_commit), 128'd1);
    rst_n = 0; #1;
    chk("mid_rst", 128'(monitor_commit), 128'd0);
    tick(); rst_n = 1; tick();
    chk("post_rst", 128'(monitor_commit), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
